// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, the latched
// request record and the wait-counter width.
package dmem_pkg;

  // Wait counter width; holds Latency-1 for Latency up to 15.
  localparam int LatWidth = 4;

  // Width of the index and wdata fields in the latched request.
  // The responder supports DWidth values up to this width.
  localparam int ReqWidth = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  // Request captured in the accept cycle; index is the word index.
  typedef struct packed {
    logic                write;
    logic                bank;
    logic [ReqWidth-1:0] index;
    logic [ReqWidth-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_bank.sv
// Single-port word array with a combinational read and a write that
// commits at the clock edge when both en_i and we_i are high.
module dmem_bank #(
  parameter int DWidth = 32,
  parameter int Depth  = 1024
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] index_i,
  input  logic [DWidth-1:0]        wdata_i,
  output logic [DWidth-1:0]        rdata_o
);

  logic [DWidth-1:0] mem_q [Depth];

  // Commit a write; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[index_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[index_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: main memory plus scratch pad behind a
// req/ready handshake with programmable wait states.
// Optional statistics counters: define DMEM_RESPONDER_STATS_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DWidth       = 32,
  parameter int Depth        = 1024,
  parameter int ScratchDepth = 64,
  parameter int Latency      = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dmem_req_i,
  input  logic              dmem_write_i,
  input  logic [DWidth-1:0] dmem_addr_i,
  input  logic [DWidth-1:0] dmem_wdata_i,
  input  logic              scratch_req_i,
  output logic              dmem_ready_o,
  output logic [DWidth-1:0] dmem_rdata_o,
  output logic              err_o
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o,
  output logic [31:0]       err_cnt_o
`endif
);

  localparam int MIdxW = $clog2(Depth);
  localparam int SIdxW = $clog2(ScratchDepth);

  dmem_state_e          state_q;
  logic [LatWidth-1:0]  cnt_q;
  dmem_req_t            req_q;
  dmem_req_t            req_d;
  logic                 resp;
  logic                 req_oor;
  logic                 main_en;
  logic                 scratch_en;
  logic [DWidth-1:0]    main_rdata;
  logic [DWidth-1:0]    scratch_rdata;

  // Assemble the request record from the bus; address bits [1:0] dropped.
  always_comb begin
    req_d       = '0;
    req_d.write = dmem_write_i;
    req_d.bank  = scratch_req_i;
    req_d.index = ReqWidth'(dmem_addr_i[DWidth-1:2]);
    req_d.wdata = ReqWidth'(dmem_wdata_i);
  end

  // Accept in IDLE, count wait states for main memory, respond for one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dmem_req_i) begin
            req_q <= req_d;
            if (scratch_req_i || (Latency == 1)) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= LatWidth'(Latency - 1);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == LatWidth'(1)) begin
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp    = (state_q == RESP);
  assign req_oor = req_q.bank ? (req_q.index >= ReqWidth'(ScratchDepth))
                              : (req_q.index >= ReqWidth'(Depth));

  // Out-of-range accesses never touch either array.
  assign main_en    = resp && !req_q.bank && !req_oor;
  assign scratch_en = resp &&  req_q.bank && !req_oor;

  dmem_bank #(
    .DWidth (DWidth),
    .Depth  (Depth)
  ) u_main (
    .clk_i   (clk_i),
    .en_i    (main_en),
    .we_i    (req_q.write),
    .index_i (req_q.index[MIdxW-1:0]),
    .wdata_i (req_q.wdata[DWidth-1:0]),
    .rdata_o (main_rdata)
  );

  dmem_bank #(
    .DWidth (DWidth),
    .Depth  (ScratchDepth)
  ) u_scratch (
    .clk_i   (clk_i),
    .en_i    (scratch_en),
    .we_i    (req_q.write),
    .index_i (req_q.index[SIdxW-1:0]),
    .wdata_i (req_q.wdata[DWidth-1:0]),
    .rdata_o (scratch_rdata)
  );

  assign dmem_ready_o = resp;
  assign err_o        = resp && req_oor;
  assign dmem_rdata_o = (resp && !req_q.write && !req_oor)
                        ? (req_q.bank ? scratch_rdata : main_rdata)
                        : '0;

`ifdef DMEM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [31:0] err_cnt_q;

  // Saturating per-response counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (resp) begin
      if (!req_q.write && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (req_q.write && (wr_cnt_q != '1))  wr_cnt_q <= wr_cnt_q + 1'b1;
      if (req_oor && (err_cnt_q != '1))     err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (Latency=2, Depth=1024,
// ScratchDepth=64). Define DMEM_RESPONDER_STATS_EN to also check counters.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        scratch;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
`ifdef DMEM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_rd_n = 0;
  int exp_wr_n = 0;
  int exp_err_n = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    bit          w;
    bit          s;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    bit          drop;
  } vec_t;

  exp_t sb[$];
  localparam int NV = 20;
  vec_t vecs[NV];

  dmem_responder #(
    .DWidth       (32),
    .Depth        (1024),
    .ScratchDepth (64),
    .Latency      (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .dmem_req_i    (req),
    .dmem_write_i  (write),
    .dmem_addr_i   (addr),
    .dmem_wdata_i  (wdata),
    .scratch_req_i (scratch),
    .dmem_ready_o  (ready),
    .dmem_rdata_o  (rdata),
    .err_o         (err)
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    .rd_cnt_o      (rd_cnt),
    .wr_cnt_o      (wr_cnt),
    .err_cnt_o     (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle; returns at the same phase.
  task automatic run_txn(input bit w, input bit s, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input bit exp_err, input int exp_lat, input bit drop);
    exp_t e;
    bit   got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb.push_back(e);
    if (w) exp_wr_n++; else exp_rd_n++;
    if (exp_err) exp_err_n++;
    req = 1'b1; write = w; scratch = s; addr = a; wdata = d;
    got = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk); #1;
      if (drop && k == 1 && !ready) req = 1'b0;
      if (ready) begin
        got = 1;
        req = 1'b0;
        e = sb.pop_front();
        check("latency", 32'(k), 32'(e.lat));
        check("rdata", rdata, e.rdata);
        check("err", {31'b0, err}, {31'b0, e.err});
        $display("txn w=%0d s=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 w, s, a, d, rdata, err, k);
      end else begin
        check("rdata_idle", rdata, 32'h0);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%h actual=no_ready required=ready", a);
      if (sb.size() > 0) void'(sb.pop_front());
      req = 1'b0;
    end
    @(posedge clk); #1;
    check("ready_after_resp", {31'b0, ready}, 32'h0);
  endtask

  initial begin
    int   last;
    int   pulses;
    bit   toggle;
    bit   done;
    exp_t e;

    //           w     s     addr           wdata          rdata          err   lat drop
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0, 2, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h1234_5678, 32'h0,         1'b0, 2, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_01FF, 32'h0,         1'b0, 1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'h0000_01FF, 1'b0, 1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 1'b0, 2, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1, 2, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_1000, 32'hAAAA_5555, 32'h0,         1'b1, 2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0, 2, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_005A, 32'h0,         1'b0, 1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_0BAD, 32'h0,         1'b1, 1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h0000_005A, 1'b0, 1, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 32'h0000_00FC, 32'h0000_0077, 32'h0,         1'b0, 1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 32'h0000_00FC, 32'h0,         32'h0000_0077, 1'b0, 1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0,         32'h0,         1'b1, 2, 1'b0};

    rst_n = 1'b0; req = 1'b0; write = 1'b0; addr = '0; wdata = '0; scratch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
`ifdef DMEM_RESPONDER_STATS_EN
    check("reset_rd_cnt", rd_cnt, 32'h0);
    check("reset_wr_cnt", wr_cnt, 32'h0);
    check("reset_err_cnt", err_cnt, 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].w, vecs[i].s, vecs[i].addr, vecs[i].wdata,
              vecs[i].rdata, vecs[i].err, vecs[i].lat, vecs[i].drop);
    end

    // Request held high with alternating addresses: one pulse every 3 cycles.
    req = 1'b1; write = 1'b0; scratch = 1'b0; addr = 32'h10; toggle = 0;
    e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; e.lat = 0;
    sb.push_back(e);
    exp_rd_n++;
    last = 0; pulses = 0; done = 0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(posedge clk); #1;
      if (ready) begin
        pulses++;
        check("b2b_gap", 32'(cyc - last), (pulses == 1) ? 32'd2 : 32'd3);
        e = sb.pop_front();
        check("b2b_rdata", rdata, e.rdata);
        $display("txn b2b addr=%h rdata=%h cycle=%0d", addr, rdata, cyc);
        last = cyc;
        if (pulses == 8) begin
          req = 1'b0;
          done = 1;
        end else begin
          toggle = ~toggle;
          addr = toggle ? 32'h8 : 32'h10;
          e.rdata = toggle ? 32'h1234_5678 : 32'hDEAD_BEEF;
          sb.push_back(e);
          exp_rd_n++;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL b2b_pulses actual=%0d required=8", pulses);
      req = 1'b0;
      sb.delete();
    end
    @(posedge clk); #1;
    check("b2b_ready_after", {31'b0, ready}, 32'h0);

    // Reset during WAIT of a write: no ready, old value survives.
    run_txn(1'b1, 1'b0, 32'h20, 32'h5, 32'h0, 1'b0, 2, 1'b0);
    req = 1'b1; write = 1'b1; scratch = 1'b0; addr = 32'h20; wdata = 32'h99;
    @(posedge clk); #1;
    check("rst_mid_ready_wait", {31'b0, ready}, 32'h0);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, ready}, 32'h0);
    check("rst_mid_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rd_n = 0; exp_wr_n = 0; exp_err_n = 0;
    @(posedge clk); #1;
    check("rst_after_ready", {31'b0, ready}, 32'h0);
    @(posedge clk); #1;
    check("rst_after_ready2", {31'b0, ready}, 32'h0);
    $display("txn reset_mid_write addr=00000020 aborted");
    run_txn(1'b0, 1'b0, 32'h20, 32'h0, 32'h5, 1'b0, 2, 1'b0);

`ifdef DMEM_RESPONDER_STATS_EN
    check("rd_cnt", rd_cnt, 32'(exp_rd_n));
    check("wr_cnt", wr_cnt, 32'(exp_wr_n));
    check("err_cnt", err_cnt, 32'(exp_err_n));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
